// File: rtl/usr_shift_ctrl_if.sv
// Command/completion bus between software-visible command port and the shift sequencer.
interface usr_shift_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [AMT_W-1:0] cmd_amt;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_fill;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] result;

  modport master (
    output cmd_valid, cmd_op, cmd_amt, cmd_data, cmd_fill,
    input  cmd_ready, busy, done, err, result
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_amt, cmd_data, cmd_fill,
    output cmd_ready, busy, done, err, result
  );
endinterface

// File: rtl/usr_shift_ctrl.sv
// Sequencer driving a universal shift register for LOAD / SHR / SHL / ROR / ROL commands.
// Optional abort input enabled with `define USR_CTRL_ABORT_EN.
module usr_shift_ctrl #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  usr_shift_ctrl_if.slave  cmd,
`ifdef USR_CTRL_ABORT_EN
  input  logic             abort_i,
`endif
  output logic [1:0]       sr_mode_o,
  output logic [WIDTH-1:0] sr_pload_o,
  output logic             sr_sin_left_o,
  output logic             sr_sin_right_o,
  input  logic [WIDTH-1:0] sr_q_i
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_SHR  = 3'd1;
  localparam logic [2:0] OP_SHL  = 3'd2;
  localparam logic [2:0] OP_ROR  = 3'd3;
  localparam logic [2:0] OP_ROL  = 3'd4;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [AMT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             fill_q, fill_d;
  logic             err_q, err_d;
  logic             accept;
  logic             abortHit;

`ifdef USR_CTRL_ABORT_EN
  assign abortHit = abort_i;
`else
  assign abortHit = 1'b0;
`endif

  assign cmd.cmd_ready = (state_q == IDLE);
  assign cmd.busy      = (state_q != IDLE);
  assign cmd.done      = (state_q == DONE);
  assign cmd.err       = (state_q == DONE) && err_q;
  assign cmd.result    = (state_q == DONE) ? sr_q_i : '0;
  assign accept        = cmd.cmd_valid && (state_q == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      count_q <= '0;
      data_q  <= '0;
      fill_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      count_q <= count_d;
      data_q  <= data_d;
      fill_q  <= fill_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    count_d        = count_q;
    data_d         = data_q;
    fill_d         = fill_q;
    err_d          = err_q;
    sr_mode_o      = 2'b00;
    sr_pload_o     = '0;
    sr_sin_left_o  = 1'b0;
    sr_sin_right_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = cmd.cmd_op;
          count_d = cmd.cmd_amt;
          data_d  = cmd.cmd_data;
          fill_d  = cmd.cmd_fill;
          err_d   = 1'b0;
          if (cmd.cmd_op > OP_ROL) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (cmd.cmd_op == OP_LOAD) begin
            state_d = LOAD;
          end else if (cmd.cmd_amt == '0) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end

      LOAD: begin
        state_d = DONE;
        if (abortHit) begin
          err_d = 1'b1;
        end else begin
          sr_mode_o  = 2'b11;
          sr_pload_o = data_q;
        end
      end

      SHIFT: begin
        if (abortHit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          // Rotates feed the bit falling off the far end back in the same cycle.
          case (op_q)
            OP_SHR: begin
              sr_mode_o     = 2'b01;
              sr_sin_left_o = fill_q;
            end
            OP_SHL: begin
              sr_mode_o      = 2'b10;
              sr_sin_right_o = fill_q;
            end
            OP_ROR: begin
              sr_mode_o     = 2'b01;
              sr_sin_left_o = sr_q_i[0];
            end
            OP_ROL: begin
              sr_mode_o      = 2'b10;
              sr_sin_right_o = sr_q_i[WIDTH-1];
            end
            default: sr_mode_o = 2'b00;
          endcase
          count_d = count_q - AMT_W'(1);
          if (count_q == AMT_W'(1)) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_usr_shift_ctrl.sv
// Directed self-checking bench for usr_shift_ctrl with a behavioural 4-bit universal shift register.
module tb_usr_shift_ctrl;
  logic       clk;
  logic       rst;
  logic [1:0] srMode;
  logic [3:0] srPload;
  logic       srSinLeft;
  logic       srSinRight;
  logic [3:0] srQ;
`ifdef USR_CTRL_ABORT_EN
  logic       abortIn;
`endif

  int passCount;
  int checkCount;

  usr_shift_ctrl_if #(.WIDTH(4), .AMT_W(3)) cmdIf ();

  usr_shift_ctrl #(.WIDTH(4), .AMT_W(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd            (cmdIf),
`ifdef USR_CTRL_ABORT_EN
    .abort_i        (abortIn),
`endif
    .sr_mode_o      (srMode),
    .sr_pload_o     (srPload),
    .sr_sin_left_o  (srSinLeft),
    .sr_sin_right_o (srSinRight),
    .sr_q_i         (srQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controlled register: 00 hold, 01 shift right, 10 shift left, 11 load.
  always_ff @(posedge clk) begin
    if (rst) begin
      srQ <= 4'b0000;
    end else begin
      case (srMode)
        2'b01:   srQ <= {srSinLeft, srQ[3:1]};
        2'b10:   srQ <= {srQ[2:0], srSinRight};
        2'b11:   srQ <= srPload;
        default: srQ <= srQ;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Presents a command for one cycle; returns in the cycle after acceptance.
  task automatic applyStimulus(input logic [2:0] op, input logic [2:0] amt,
                               input logic [3:0] data, input logic fill);
    cmdIf.cmd_valid = 1'b1;
    cmdIf.cmd_op    = op;
    cmdIf.cmd_amt   = amt;
    cmdIf.cmd_data  = data;
    cmdIf.cmd_fill  = fill;
    tick();
    cmdIf.cmd_valid = 1'b0;
    cmdIf.cmd_data  = 4'b0000;
    cmdIf.cmd_fill  = 1'b0;
  endtask

  task automatic loadReg(input logic [3:0] data);
    applyStimulus(3'b000, 3'd0, data, 1'b0);
    tick();
    tick();
  endtask

  initial begin
    passCount       = 0;
    checkCount      = 0;
    rst             = 1'b1;
    cmdIf.cmd_valid = 1'b0;
    cmdIf.cmd_op    = 3'b000;
    cmdIf.cmd_amt   = 3'd0;
    cmdIf.cmd_data  = 4'b0000;
    cmdIf.cmd_fill  = 1'b0;
`ifdef USR_CTRL_ABORT_EN
    abortIn         = 1'b0;
`endif
    tick();
    tick();
    checkOutput("rst_ready", 8'(cmdIf.cmd_ready), 8'h1);
    checkOutput("rst_busy", 8'(cmdIf.busy), 8'h0);
    checkOutput("rst_done", 8'(cmdIf.done), 8'h0);
    checkOutput("rst_err", 8'(cmdIf.err), 8'h0);
    checkOutput("rst_result", 8'(cmdIf.result), 8'h0);
    checkOutput("rst_mode", 8'(srMode), 8'h0);
    checkOutput("rst_pload", 8'(srPload), 8'h0);
    checkOutput("rst_sin", 8'({srSinLeft, srSinRight}), 8'h0);
    rst = 1'b0;

    // LOAD 1011
    applyStimulus(3'b000, 3'd0, 4'b1011, 1'b0);
    checkOutput("load_mode_t1", 8'(srMode), 8'h3);
    checkOutput("load_pload_t1", 8'(srPload), 8'hb);
    checkOutput("load_busy_t1", 8'(cmdIf.busy), 8'h1);
    checkOutput("load_ready_t1", 8'(cmdIf.cmd_ready), 8'h0);
    checkOutput("load_done_t1", 8'(cmdIf.done), 8'h0);
    tick();
    checkOutput("load_done_t2", 8'(cmdIf.done), 8'h1);
    checkOutput("load_err_t2", 8'(cmdIf.err), 8'h0);
    checkOutput("load_result_t2", 8'(cmdIf.result), 8'hb);
    checkOutput("load_mode_t2", 8'(srMode), 8'h0);
    checkOutput("load_pload_t2", 8'(srPload), 8'h0);
    tick();
    checkOutput("load_done_t3", 8'(cmdIf.done), 8'h0);
    checkOutput("load_result_t3", 8'(cmdIf.result), 8'h0);
    checkOutput("load_ready_t3", 8'(cmdIf.cmd_ready), 8'h1);

    // SHR 2 fill 0 from 1011 -> 0010
    applyStimulus(3'b001, 3'd2, 4'b1111, 1'b0);
    checkOutput("shr_mode_t1", 8'(srMode), 8'h1);
    checkOutput("shr_sinl_t1", 8'(srSinLeft), 8'h0);
    tick();
    checkOutput("shr_mode_t2", 8'(srMode), 8'h1);
    checkOutput("shr_done_t2", 8'(cmdIf.done), 8'h0);
    tick();
    checkOutput("shr_done_t3", 8'(cmdIf.done), 8'h1);
    checkOutput("shr_result_t3", 8'(cmdIf.result), 8'h2);
    checkOutput("shr_mode_t3", 8'(srMode), 8'h0);
    tick();

    // ROL 1 from 1011 -> 0111, then ROR 4 -> 0111
    loadReg(4'b1011);
    applyStimulus(3'b100, 3'd1, 4'b0000, 1'b0);
    checkOutput("rol_mode_t1", 8'(srMode), 8'h2);
    checkOutput("rol_sinr_t1", 8'(srSinRight), 8'h1);
    tick();
    checkOutput("rol_done_t2", 8'(cmdIf.done), 8'h1);
    checkOutput("rol_result_t2", 8'(cmdIf.result), 8'h7);
    tick();
    applyStimulus(3'b011, 3'd4, 4'b0000, 1'b0);
    checkOutput("ror_sinl_t1", 8'(srSinLeft), 8'h1);
    for (int i = 1; i <= 4; i++) begin
      checkOutput($sformatf("ror_mode_t%0d", i), 8'(srMode), 8'h1);
      checkOutput($sformatf("ror_done_t%0d", i), 8'(cmdIf.done), 8'h0);
      tick();
    end
    checkOutput("ror_done_t5", 8'(cmdIf.done), 8'h1);
    checkOutput("ror_err_t5", 8'(cmdIf.err), 8'h0);
    checkOutput("ror_result_t5", 8'(cmdIf.result), 8'h7);
    tick();

    // SHL 5 fill 1 from 0010 -> 1111
    loadReg(4'b0010);
    applyStimulus(3'b010, 3'd5, 4'b0000, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      checkOutput($sformatf("shl_mode_t%0d", i), 8'(srMode), 8'h2);
      checkOutput($sformatf("shl_sinr_t%0d", i), 8'(srSinRight), 8'h1);
      tick();
    end
    checkOutput("shl_done_t6", 8'(cmdIf.done), 8'h1);
    checkOutput("shl_err_t6", 8'(cmdIf.err), 8'h0);
    checkOutput("shl_result_t6", 8'(cmdIf.result), 8'hf);
    tick();

    // Illegal op with valid held through DONE, then SHR amt 0
    loadReg(4'b0101);
    cmdIf.cmd_valid = 1'b1;
    cmdIf.cmd_op    = 3'b111;
    cmdIf.cmd_amt   = 3'd2;
    tick();
    cmdIf.cmd_op  = 3'b001;
    cmdIf.cmd_amt = 3'd0;
    checkOutput("ill_mode_t1", 8'(srMode), 8'h0);
    checkOutput("ill_done_t1", 8'(cmdIf.done), 8'h1);
    checkOutput("ill_err_t1", 8'(cmdIf.err), 8'h1);
    checkOutput("ill_result_t1", 8'(cmdIf.result), 8'h5);
    checkOutput("ill_ready_t1", 8'(cmdIf.cmd_ready), 8'h0);
    tick();
    checkOutput("held_ready_t2", 8'(cmdIf.cmd_ready), 8'h1);
    checkOutput("held_done_t2", 8'(cmdIf.done), 8'h0);
    tick();
    cmdIf.cmd_valid = 1'b0;
    checkOutput("amt0_done", 8'(cmdIf.done), 8'h1);
    checkOutput("amt0_err", 8'(cmdIf.err), 8'h0);
    checkOutput("amt0_result", 8'(cmdIf.result), 8'h5);
    checkOutput("amt0_mode", 8'(srMode), 8'h0);
    tick();

    // Reset in the middle of SHR 3
    applyStimulus(3'b001, 3'd3, 4'b0000, 1'b0);
    checkOutput("abrt_busy_t1", 8'(cmdIf.busy), 8'h1);
    tick();
    rst = 1'b1;
    checkOutput("abrt_mode_t2", 8'(srMode), 8'h1);
    tick();
    rst = 1'b0;
    checkOutput("abrt_ready_t3", 8'(cmdIf.cmd_ready), 8'h1);
    checkOutput("abrt_busy_t3", 8'(cmdIf.busy), 8'h0);
    checkOutput("abrt_mode_t3", 8'(srMode), 8'h0);
    checkOutput("abrt_done_t3", 8'(cmdIf.done), 8'h0);
    for (int i = 4; i <= 8; i++) begin
      tick();
      checkOutput($sformatf("abrt_nodone_t%0d", i), 8'(cmdIf.done), 8'h0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule

// File: doc/usr_shift_ctrl.md
Name: usr_shift_ctrl

Overview:
- Command sequencer for one 4-bit universal shift register instance (modes: 00 hold, 01 shift right, 10 shift left, 11 parallel load).
- Accepts one command at a time (load, logical shift, rotate by N) over a valid/ready handshake.
- Drives the register's mode, parallel and serial inputs for the required number of cycles, then pulses done with the register contents.
- Sits between a software-visible command interface and the shift register datapath.

Parameters:
- WIDTH, 4, data width of the controlled register.
- AMT_W, 3, width of the shift-amount field.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  3  operation: 000 LOAD, 001 SHR, 010 SHL, 011 ROR, 100 ROL, 101-111 illegal.
- cmd_amt  in  AMT_W  number of single-bit shift cycles; ignored for LOAD.
- cmd_data  in  WIDTH  LOAD data.
- cmd_fill  in  1  fill bit for SHR/SHL.
- sr_mode  out  2  to register mode input.
- sr_pload  out  WIDTH  to register parallel input.
- sr_sin_left  out  1  to register serial-in, enters MSB on shift right.
- sr_sin_right  out  1  to register serial-in, enters LSB on shift left.
- sr_q  in  WIDTH  register output.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 = illegal op or abort.
- result  out  WIDTH  equals sr_q while done=1; 0 otherwise.

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst.
- Reset values: IDLE; cmd_ready=1; sr_mode=00; sr_pload=0; sr_sin_left=0; sr_sin_right=0; busy=0; done=0; err=0; result=0; internal op/amt/data/fill/count registers=0.
- Handshake: accept when cmd_valid && cmd_ready, in cycle T. cmd_ready=1 only in IDLE. Fields are latched at acceptance; input changes afterwards have no effect.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: sr_mode=00. On accept:
  - illegal op -> DONE with err=1.
  - LOAD -> LOAD.
  - shift or rotate with amt=0 -> DONE with err=0, no register activity.
  - otherwise -> SHIFT with count=amt.
- LOAD: exactly one cycle; sr_mode=11, sr_pload=latched data; then DONE.
- SHIFT: one register shift per cycle; count decrements each cycle; exits to DONE after the cycle in which count==1.
  - SHR: sr_mode=01, sr_sin_left=fill.
  - SHL: sr_mode=10, sr_sin_right=fill.
  - ROR: sr_mode=01, sr_sin_left=sr_q[0] (combinational).
  - ROL: sr_mode=10, sr_sin_right=sr_q[WIDTH-1] (combinational).
- DONE: one cycle; sr_mode=00; done=1; result=sr_q; err as determined; then IDLE.
- sr_mode=00 in every state and cycle not listed above.
- Latency, accept at T:
  - LOAD: done at T+2.
  - shift/rotate of N>0: done at T+N+1.
  - illegal op or amt=0: done at T+1.
- Back-to-back: next accept no earlier than the cycle after DONE, so there is one bubble between commands.
- Amount: no clipping. SHR/SHL with amt>=WIDTH yield all-fill. Rotate by WIDTH returns the original value and still takes WIDTH cycles.
- Serial inputs not in use are driven 0. sr_pload=0 outside LOAD.
- Reset mid-operation: next cycle IDLE, sr_mode=00, no done pulse. Register contents are governed by the register's own reset.
- cmd_valid held in DONE is not accepted until IDLE.

Optional Feature:
- Macro: USR_CTRL_ABORT_EN.
- Defined: adds input abort (1 bit). abort=1 in LOAD or SHIFT forces sr_mode=00 in that cycle (the shift/load is suppressed) and goes to DONE next cycle with err=1. Partial shifts already applied remain in the register. abort is ignored in IDLE and DONE.
- Undefined: no abort port; commands always run to completion.

Test Plan:
- rst, then LOAD data=1011 at T -> sr_mode=11 at T+1 only; done=1, err=0, result=1011 at T+2.
- From 1011, SHR amt=2 fill=0 -> sr_mode=01 at T+1..T+2; done at T+3, result=0010.
- From 1011, ROL amt=1 -> sr_sin_right=1 at T+1; done at T+2, result=0111. Then ROR amt=4 -> result=0111, done at T+5.
- From 0010, SHL amt=5 fill=1 -> five cycles of sr_mode=10; done at T+6, result=1111, err=0.
- op=111 with register at 0101 -> sr_mode stays 00; done=1, err=1, result=0101 at T+1. SHR amt=0 -> done at T+1, err=0.
- SHR amt=3 accepted; rst=1 at T+2 -> at T+3 IDLE, cmd_ready=1, busy=0, sr_mode=00; no done pulse ever.
